msx_mouse_port: RTL and testbench

- Converts MiST user_io relative mouse reports into the MSX mouse nibble protocol for one general-purpose joystick port.
- Sits between user_io (mouse_x/y/flags/strobe) and emsx_top joystick port A.
- Multiplexes mouse data with the digital joystick. The top level keeps only the open-drain (Z) conversion.
- Unlike an inline latch, it accumulates all reports between MSX reads and snapshots X/Y coherently, so no motion is lost.

---
 rtl/msx_mouse_port_if.sv | 34 +++
 rtl/msx_mouse_port.sv | 147 ++++++++++++++
 tb/tb_msx_mouse_port.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/msx_mouse_port_if.sv
// Bundle between user_io, the joystick input and emsx_top port A for msx_mouse_port.
// slave = the converter; master = whatever drives the mouse/joystick side and reads the pins.
interface msx_mouse_port_if;
    logic signed [8:0] mouse_x;
    logic signed [8:0] mouse_y;
    logic [7:0]        mouse_flags;
    logic              mouse_strobe;
    logic [5:0]        joy_n;
    logic              stra;
    logic [5:0]        port_dout;
    logic              mouse_en;

    modport slave (
        input  mouse_x,
        input  mouse_y,
        input  mouse_flags,
        input  mouse_strobe,
        input  joy_n,
        input  stra,
        output port_dout,
        output mouse_en
    );

    modport master (
        output mouse_x,
        output mouse_y,
        output mouse_flags,
        output mouse_strobe,
        output joy_n,
        output stra,
        input  port_dout,
        input  mouse_en
    );
endinterface

// File: rtl/msx_mouse_port.sv
// MSX mouse nibble protocol for one joystick port, muxed with the digital joystick.
// Macro MSX_MOUSE_SAT_EN: when defined, snapshots clamp to [-128,127]; otherwise they wrap.
module msx_mouse_port #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ACC_W          = 10
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    msx_mouse_port_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic signed [ACC_W:0] S8_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] S8_MIN = (ACC_W+1)'(-128);

`ifdef MSX_MOUSE_SAT_EN
    localparam bit SAT8_CLAMP = 1'b1;
`else
    localparam bit SAT8_CLAMP = 1'b0;
`endif

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t                   state_q;
    logic                     stra_q;
    logic                     mouse_en_q;
    logic                     mouse_en_d;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0]  acc_y_q, acc_y_d;
    logic [7:0]               snap_x_q, snap_y_q;
    logic [7:0]               snap_x_new, snap_y_new;
    logic [5:0]               dout_q;
    logic                     toggle;
    logic signed [ACC_W-1:0]  ext_x, ext_y;

    wire unused_flags = &{1'b0, bus.mouse_flags[7:2]};

    // Add a 9-bit delta to the accumulator, pinning at the signed limits instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [8:0]       d
    );
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(d);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [7:0] sat8(input logic signed [ACC_W:0] v);
        logic [7:0] clamped;
        if (v > S8_MAX)
            clamped = 8'h7F;
        else if (v < S8_MIN)
            clamped = 8'h80;
        else
            clamped = v[7:0];
        return SAT8_CLAMP ? clamped : v[7:0];
    endfunction

    always_comb begin
        toggle     = (bus.stra != stra_q) && mouse_en_q;
        ext_x      = ACC_W'(bus.mouse_x);
        ext_y      = ACC_W'(bus.mouse_y);
        // MSX X axis is inverted relative to user_io; the extra bit keeps -min representable.
        snap_x_new = sat8(-((ACC_W+1)'(acc_x_q)));
        snap_y_new = sat8((ACC_W+1)'(acc_y_q));

        mouse_en_d = mouse_en_q;
        if (bus.mouse_strobe)
            mouse_en_d = 1'b1;
        else if (bus.joy_n != 6'h3F)
            mouse_en_d = 1'b0;

        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        if (bus.mouse_strobe) begin
            acc_x_d = sat_add(acc_x_q, bus.mouse_x);
            acc_y_d = sat_add(acc_y_q, bus.mouse_y);
        end
        // Snapshot takes the old totals; a coincident report starts the next window.
        if (toggle && state_q == S0) begin
            acc_x_d = bus.mouse_strobe ? ext_x : '0;
            acc_y_d = bus.mouse_strobe ? ext_y : '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S0;
            stra_q     <= 1'b0;
            mouse_en_q <= 1'b0;
            cnt_q      <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            dout_q     <= 6'h3F;
        end else begin
            stra_q     <= bus.stra;
            mouse_en_q <= mouse_en_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;

            if (!mouse_en_q) begin
                dout_q  <= bus.joy_n;
                state_q <= S0;
                cnt_q   <= '0;
            end else begin
                dout_q[5:4] <= ~bus.mouse_flags[1:0];
                if (toggle) begin
                    cnt_q <= CNT_RELOAD;
                    case (state_q)
                        S0: begin
                            snap_x_q    <= snap_x_new;
                            snap_y_q    <= snap_y_new;
                            dout_q[3:0] <= snap_x_new[7:4];
                            state_q     <= S1;
                        end
                        S1: begin
                            dout_q[3:0] <= snap_x_q[3:0];
                            state_q     <= S2;
                        end
                        S2: begin
                            dout_q[3:0] <= snap_y_q[7:4];
                            state_q     <= S3;
                        end
                        default: begin
                            dout_q[3:0] <= snap_y_q[3:0];
                            state_q     <= S0;
                        end
                    endcase
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_q <= S0;
                end
            end
        end
    end

    assign bus.port_dout = dout_q;
    assign bus.mouse_en  = mouse_en_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed bench for msx_mouse_port: vector table plus hand-written timeout and reset sequences.
module tb_msx_mouse_port;

    localparam int TO = 200;

`ifdef MSX_MOUSE_SAT_EN
    localparam logic [3:0] XH = 4'h8;
    localparam logic [3:0] XL = 4'h0;
`else
    localparam logic [3:0] XH = 4'hD;
    localparam logic [3:0] XL = 4'h4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msx_mouse_port_if bus();

    msx_mouse_port #(.TIMEOUT_CYCLES(TO), .ACC_W(10)) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       strb;
        logic [8:0] mx;
        logic [8:0] my;
        logic [1:0] flg;
        logic       tog;
        logic [5:0] joy;
        logic       ck_dout;
        logic       ck_en;
        logic [5:0] exp_dout;
        logic       exp_en;
        int         gap;
    } vec_t;

    vec_t vt[29];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic strb, logic [8:0] mx, logic [8:0] my, logic [1:0] flg,
                                logic tog, logic [5:0] joy, logic ck_dout, logic ck_en,
                                logic [5:0] exp_dout, logic exp_en, int gap);
        vec_t v;
        v.strb = strb; v.mx = mx; v.my = my; v.flg = flg; v.tog = tog; v.joy = joy;
        v.ck_dout = ck_dout; v.ck_en = ck_en; v.exp_dout = exp_dout; v.exp_en = exp_en;
        v.gap = gap;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk6(string name, logic [5:0] act, logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: port_dout=%h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: mouse_en=%b expected %b", name, act, exp);
        end
    endtask

    task automatic toggle_chk(string name, logic [5:0] exp);
        bus.stra = ~bus.stra;
        tick();
        chk6(name, bus.port_dout, exp);
        $display("toggle %s: port_dout=%h", name, bus.port_dout);
        repeat (3) tick();
    endtask

    initial begin
        // Test 1: +5/-3 report, four nibbles, then a button pattern.
        vt[0]  = mk(1, 9'd5,     9'h1FD, 2'b00, 0, 6'h3F, 1, 1, 6'h3F, 1, 2);
        vt[1]  = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3F, 1, 19);
        vt[2]  = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3B, 1, 19);
        vt[3]  = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3F, 1, 19);
        vt[4]  = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3D, 1, 3);
        vt[5]  = mk(0, 9'd0,     9'd0,   2'b11, 0, 6'h3F, 1, 1, 6'h0D, 1, 0);
        vt[6]  = mk(0, 9'd0,     9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3D, 1, 0);
        // Test 2: X total +300, snapshot saturates or wraps.
        vt[7]  = mk(1, 9'd100,   9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3D, 1, 0);
        vt[8]  = mk(1, 9'd100,   9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3D, 1, 0);
        vt[9]  = mk(1, 9'd100,   9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3D, 1, 2);
        vt[10] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, {2'b11, XH}, 1, 3);
        vt[11] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, {2'b11, XL}, 1, 3);
        vt[12] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        vt[13] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        // Test 4: report coincident with the S0 toggle lands in the next window.
        vt[14] = mk(1, 9'h1F0,   9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h30, 1, 2);
        vt[15] = mk(1, 9'd2,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h31, 1, 3);
        vt[16] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        vt[17] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        vt[18] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        vt[19] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3F, 1, 3);
        vt[20] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h3E, 1, 3);
        vt[21] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        vt[22] = mk(0, 9'd0,     9'd0,   2'b00, 1, 6'h3F, 1, 1, 6'h30, 1, 3);
        // Test 5: joystick activity drops mouse mode; a strobe wins over it.
        vt[23] = mk(0, 9'd0,     9'd0,   2'b00, 0, 6'h3E, 0, 1, 6'h00, 0, 0);
        vt[24] = mk(0, 9'd0,     9'd0,   2'b00, 0, 6'h3E, 1, 1, 6'h3E, 0, 0);
        vt[25] = mk(1, 9'd0,     9'd0,   2'b00, 0, 6'h3E, 1, 1, 6'h3E, 1, 0);
        vt[26] = mk(0, 9'd0,     9'd0,   2'b00, 0, 6'h3E, 0, 1, 6'h00, 0, 0);
        vt[27] = mk(0, 9'd0,     9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3F, 0, 0);
        vt[28] = mk(1, 9'd0,     9'd0,   2'b00, 0, 6'h3F, 1, 1, 6'h3F, 1, 2);

        bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_flags = '0; bus.mouse_strobe = 1'b0;
        bus.joy_n = 6'h3F; bus.stra = 1'b0;
        repeat (3) tick();
        chk6("reset_dout", bus.port_dout, 6'h3F);
        chk1("reset_en", bus.mouse_en, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 29; i++) begin
            bus.mouse_strobe = vt[i].strb;
            bus.mouse_x      = vt[i].mx;
            bus.mouse_y      = vt[i].my;
            bus.mouse_flags  = {6'b0, vt[i].flg};
            bus.joy_n        = vt[i].joy;
            if (vt[i].tog) bus.stra = ~bus.stra;
            tick();
            $display("vec %0d: port_dout=%h mouse_en=%b", i, bus.port_dout, bus.mouse_en);
            if (vt[i].ck_dout) chk6($sformatf("vec%0d_dout", i), bus.port_dout, vt[i].exp_dout);
            if (vt[i].ck_en)   chk1($sformatf("vec%0d_en", i), bus.mouse_en, vt[i].exp_en);
            bus.mouse_strobe = 1'b0;
            repeat (vt[i].gap) tick();
        end

        // Test 3: abandon a sequence at S2, let the timeout expire, expect a fresh S0 snapshot.
        toggle_chk("to_t1", 6'h30);
        toggle_chk("to_t2", 6'h30);
        bus.mouse_x = 9'h1CB;  // -53 -> snapshot X = 0x35
        bus.mouse_y = 9'd0;
        bus.mouse_strobe = 1'b1;
        tick();
        bus.mouse_strobe = 1'b0;
        repeat (TO + 2) tick();
        toggle_chk("to_restart_hi", 6'h33);
        toggle_chk("to_restart_lo", 6'h35);

        // Test 6: asynchronous reset in S2 with the left button held.
        bus.mouse_flags = 8'h01;
        tick();
        chk6("btn_left", bus.port_dout, 6'h25);
        #2 rst_n = 1'b0;
        #1;
        chk6("async_rst_dout", bus.port_dout, 6'h3F);
        chk1("async_rst_en", bus.mouse_en, 1'b0);
        $display("async reset: port_dout=%h mouse_en=%b", bus.port_dout, bus.mouse_en);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        bus.mouse_x = 9'd0;
        bus.mouse_strobe = 1'b1;
        tick();
        bus.mouse_strobe = 1'b0;
        chk1("post_rst_en", bus.mouse_en, 1'b1);
        chk6("post_rst_pass", bus.port_dout, 6'h3F);
        tick();
        chk6("post_rst_btn", bus.port_dout, 6'h2F);
        toggle_chk("post_rst_s0", 6'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
